// File: rtl/spi_rx_deshifter_if.sv
// ---------------------------------------------------------------------------
// spi_rx_deshifter_if
// Handshake bundle between the SPI receive shifter's holding register and the
// APB register block that drains it.
//
//   data_o   [DATA_W] received word held for the consumer
//   valid_o           holding register full
//   ready_i           consumer accepts data_o when valid_o is high
//
// Modports:
//   master : the receive shifter (drives data_o/valid_o, samples ready_i)
//   slave  : the consumer (samples data_o/valid_o, drives ready_i)
// ---------------------------------------------------------------------------
interface spi_rx_deshifter_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;

  modport master (
    output data_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    output ready_i
  );

endinterface : spi_rx_deshifter_if

// File: rtl/spi_rx_deshifter.sv
// ---------------------------------------------------------------------------
// spi_rx_deshifter
// Serial-to-parallel receive shifter for the SPI lite datapath. Samples sdi_i
// on each shift strobe and assembles a DATA_W-bit word, MSB-first or
// LSB-first, then hands it to the register block through a one-entry holding
// register with a valid/ready handshake.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   sdi_i      serial data in, sampled only when sh_en=1
//   sh_en      one-cycle shift strobe per received bit
//   sh_rl      bit order for the next frame: 1 = MSB first, 0 = LSB first
//   clr_i      abort partial frame and clear overrun_o
//   rx_if      holding-register handshake (data_o, valid_o, ready_i)
//   busy_o     frame in progress
//   overrun_o  sticky: a completed word was dropped
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module spi_rx_deshifter #(
  parameter int DATA_W = 8,
  localparam int CNT_W = $clog2(DATA_W + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      sdi_i,
  input  logic                      sh_en,
  input  logic                      sh_rl,
  input  logic                      clr_i,
  spi_rx_deshifter_if.master        rx_if,
  output logic                      busy_o,
  output logic                      overrun_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  // Registered state
  logic [CNT_W-1:0]  cnt_reg,     cnt_next;
  logic [DATA_W-1:0] sr_reg,      sr_next;
  logic              dir_reg,     dir_next;
  logic [DATA_W-1:0] data_reg,    data_next;
  logic              valid_reg,   valid_next;
  logic              busy_reg,    busy_next;
  logic              overrun_reg, overrun_next;

  // Frame state is a pure function of the bit counter, so no separate
  // state register is kept; it cannot drift out of step with cnt_reg.
  state_t            state;

  logic              dir_eff;
  logic [DATA_W-1:0] shifted;
  logic              pop;
  logic              complete;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg     <= '0;
      sr_reg      <= '0;
      dir_reg     <= 1'b1;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      sr_reg      <= sr_next;
      dir_reg     <= dir_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      busy_reg    <= busy_next;
      overrun_reg <= overrun_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state        = (cnt_reg == '0) ? IDLE : SHIFT;

    // The first bit of a frame takes its order from sh_rl directly; every
    // later bit uses the order latched with that first bit.
    dir_eff      = (state == IDLE) ? sh_rl : dir_reg;
    shifted      = dir_eff ? {sr_reg[DATA_W-2:0], sdi_i}
                           : {sdi_i, sr_reg[DATA_W-1:1]};

    pop          = valid_reg & rx_if.ready_i;
    complete     = 1'b0;

    cnt_next     = cnt_reg;
    sr_next      = sr_reg;
    dir_next     = dir_reg;
    data_next    = data_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;

    // A pop empties the holding register; a completion on the same edge
    // below refills it, so the pair nets out to valid staying high.
    if (pop) begin
      valid_next = 1'b0;
    end

    if (clr_i) begin
      cnt_next     = '0;
      sr_next      = '0;
      overrun_next = 1'b0;
    end else if (sh_en) begin
      if (state == IDLE) begin
        dir_next = sh_rl;
      end
      if (cnt_reg == LAST_CNT) begin
        complete = 1'b1;
        cnt_next = '0;
        sr_next  = '0;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
        sr_next  = shifted;
      end
    end

    if (complete) begin
      if (!valid_reg || pop) begin
        data_next  = shifted;
        valid_next = 1'b1;
      end else begin
        // Consumer still holds the previous word: keep it, drop this one.
        overrun_next = 1'b1;
      end
    end

    busy_next = (cnt_next != '0);
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign rx_if.data_o  = data_reg;
  assign rx_if.valid_o = valid_reg;
  assign busy_o        = busy_reg;
  assign overrun_o     = overrun_reg;

endmodule : spi_rx_deshifter

// File: tb/tb_spi_rx_deshifter.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_deshifter
// Directed bench for spi_rx_deshifter (DATA_W = 8). Inputs change 1 ns after
// a rising edge and outputs are read at the same point, so each read shows
// the effect of the edge just passed.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_rx_deshifter;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_i;
  logic sdi_i;
  logic sh_en;
  logic sh_rl;
  logic clr_i;
  logic busy_o;
  logic overrun_o;

  int checks = 0;
  int errors = 0;

  spi_rx_deshifter_if #(.DATA_W(DATA_W)) rx_if ();

  spi_rx_deshifter #(.DATA_W(DATA_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .sdi_i     (sdi_i),
    .sh_en     (sh_en),
    .sh_rl     (sh_rl),
    .clr_i     (clr_i),
    .rx_if     (rx_if),
    .busy_o    (busy_o),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-22s obs=%0h exp=%0h ok", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send the first n bits of w in wire order; gap idle cycles between bits
  // (none after the last, so the caller reads the completing edge directly).
  task automatic send_bits(input logic [7:0] w, input logic rl, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      sh_en = 1'b1;
      sh_rl = rl;
      sdi_i = rl ? w[7-i] : w[i];
      tick();
      sh_en = 1'b0;
      sdi_i = 1'bx;
      if (i != n - 1) repeat (gap) tick();
    end
  endtask

  task automatic pop_word();
    rx_if.ready_i = 1'b1;
    tick();
    rx_if.ready_i = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    int         pulses;

    rst_i = 1'b1; sdi_i = 1'b0; sh_en = 1'b0; sh_rl = 1'b1; clr_i = 1'b0;
    rx_if.ready_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    chk("reset data",    rx_if.data_o,  32'h0);
    chk("reset valid",   rx_if.valid_o, 32'h0);
    chk("reset busy",    busy_o,        32'h0);
    chk("reset overrun", overrun_o,     32'h0);

    // MSB first, pulses 4 cycles apart
    send_bits(8'hB2, 1'b1, 3, 3);
    chk("msb busy mid", busy_o, 32'h1);
    chk("msb valid mid", rx_if.valid_o, 32'h0);
    repeat (3) tick();
    pat = 8'hB2;
    for (int i = 3; i < 8; i++) begin
      sh_en = 1'b1; sh_rl = 1'b1; sdi_i = pat[7-i];
      tick();
      sh_en = 1'b0;
      if (i != 7) repeat (3) tick();
    end
    chk("msb data",  rx_if.data_o,  32'hB2);
    chk("msb valid", rx_if.valid_o, 32'h1);
    chk("msb busy",  busy_o,        32'h0);
    pop_word();
    chk("msb pop valid", rx_if.valid_o, 32'h0);
    chk("msb pop data",  rx_if.data_o,  32'hB2);

    // LSB first, same wire bits 1,0,1,1,0,0,1,0
    send_bits(8'h4D, 1'b0, 8, 3);
    chk("lsb data",  rx_if.data_o,  32'h4D);
    chk("lsb valid", rx_if.valid_o, 32'h1);
    pop_word();

    // LSB first with sh_rl toggled on later bits: order stays as latched
    pat = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      sh_en = 1'b1;
      sh_rl = (i >= 2 && i < 7) ? ~sh_rl : 1'b0;
      sdi_i = pat[i];
      tick();
      sh_en = 1'b0;
      if (i != 7) tick();
    end
    chk("lsb toggle data", rx_if.data_o, 32'h4D);
    pop_word();

    // Overrun, then clr
    send_bits(8'h5A, 1'b1, 8, 1);
    chk("ovr first valid", rx_if.valid_o, 32'h1);
    send_bits(8'hC3, 1'b1, 8, 1);
    chk("ovr data",    rx_if.data_o,  32'h5A);
    chk("ovr valid",   rx_if.valid_o, 32'h1);
    chk("ovr flag",    overrun_o,     32'h1);
    chk("ovr busy",    busy_o,        32'h0);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("clr overrun", overrun_o,     32'h0);
    chk("clr valid",   rx_if.valid_o, 32'h1);
    chk("clr data",    rx_if.data_o,  32'h5A);
    pop_word();

    // Pop coinciding with completion
    send_bits(8'h11, 1'b1, 8, 0);
    chk("simul first", rx_if.data_o, 32'h11);
    send_bits(8'h22, 1'b1, 7, 0);
    tick();
    rx_if.ready_i = 1'b1; sh_en = 1'b1; sh_rl = 1'b1; sdi_i = 1'b0;
    tick();
    rx_if.ready_i = 1'b0; sh_en = 1'b0;
    chk("simul data",    rx_if.data_o,  32'h22);
    chk("simul valid",   rx_if.valid_o, 32'h1);
    chk("simul overrun", overrun_o,     32'h0);
    pop_word();

    // Abort after 5 bits, then a clean frame
    send_bits(8'hFF, 1'b1, 5, 0);
    chk("abort busy pre", busy_o, 32'h1);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("abort busy", busy_o, 32'h0);
    send_bits(8'hF0, 1'b1, 8, 0);
    chk("abort data",  rx_if.data_o,  32'hF0);
    chk("abort valid", rx_if.valid_o, 32'h1);

    // Reset mid-frame with valid high; LSB order requested to check dir resets
    send_bits(8'h07, 1'b0, 3, 0);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("rst data",    rx_if.data_o,  32'h0);
    chk("rst valid",   rx_if.valid_o, 32'h0);
    chk("rst busy",    busy_o,        32'h0);
    chk("rst overrun", overrun_o,     32'h0);
    send_bits(8'h81, 1'b1, 8, 1);
    chk("post rst data", rx_if.data_o, 32'h81);
    pop_word();

    // Back-to-back: 16 consecutive strobes, ready held high
    rx_if.ready_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      pat = (i < 8) ? 8'hAA : 8'h55;
      sh_en = 1'b1; sh_rl = 1'b1; sdi_i = pat[7 - (i % 8)];
      tick();
      if (rx_if.valid_o) pulses++;
      if (i == 7)  chk("b2b word0", rx_if.data_o, 32'hAA);
      if (i == 8)  chk("b2b valid drop", rx_if.valid_o, 32'h0);
      if (i == 15) chk("b2b word1", rx_if.data_o, 32'h55);
    end
    sh_en = 1'b0;
    tick();
    rx_if.ready_i = 1'b0;
    chk("b2b pulses",  pulses,        32'd2);
    chk("b2b valid",   rx_if.valid_o, 32'h0);
    chk("b2b overrun", overrun_o,     32'h0);
    chk("b2b busy",    busy_o,        32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_spi_rx_deshifter
